instr_fetch_queue: RTL and testbench
====================================

// Module: instr_fetch_queue
// PURPOSE
//   Fetch stage directly downstream of the program counter. Each cycle it issues a read
//   of the instruction ROM at the PC address. It tags the returned word with its address
//   and buffers it in a DEPTH-entry show-ahead FIFO that feeds the decoder through a
//   valid/ready handshake. It discards all fetched work on a taken jump (pcWR) and raises
//   fetch_hold so the PC stops advancing while the queue cannot accept more words.
// PARAMETERS
//   IW     16  instruction word width
//   AW     8   address width (matches PC Addr)
//   DEPTH  4   FIFO entries; power of two, >= 2
// PORTS
//   clk         in   1    clock, all state updates on posedge
//   rst         in   1    asynchronous, active-low reset
//   stop        in   1    global halt; 1 freezes issue and pop
//   Addr        in   AW   current PC value
//   pcWR        in   1    taken jump / flush request
//   mem_addr    out  AW   ROM read address (= Addr, combinational)
//   mem_rd      out  1    ROM read strobe
//   mem_data    in   IW   ROM data; sync ROM, valid the cycle after mem_rd=1
//   fetch_hold  out  1    1 = PC must not advance (OR into PC stop)
//   ir          out  IW   instruction at FIFO head
//   ir_pc       out  AW   address of ir
//   ir_valid    out  1    ir/ir_pc hold a valid entry
//   ir_ready    in   1    decoder accepts head this cycle
// BEHAVIOUR
//   Reset (rst=0, async)
//   - count=0, read/write pointers=0, infl=0, infl_addr=0.
//   - Outputs: ir_valid=0, ir=0, ir_pc=0, fetch_hold=0, mem_rd=0.
//   State
//   - FIFO count in 0..DEPTH.
//   - infl: 1-bit in-flight flag; infl_addr: AW-bit tag of the outstanding read.
//   fetch_hold (combinational) = (count + infl) >= DEPTH.
//   mem_rd (combinational) = rst & ~stop & ~fetch_hold & ~pcWR.
//   Issue: on a posedge with mem_rd=1, set infl=1 and infl_addr=Addr; otherwise infl=0.
//   Push: on a posedge with infl=1, write {mem_data, infl_addr} at wptr and wptr++ (wraps
//     mod DEPTH). Push happens even when stop=1, so a read in flight is never lost.
//   Pop: on a posedge with ir_valid & ir_ready & ~stop, rptr++ (wraps mod DEPTH).
//   Push and pop in the same cycle: count unchanged, both pointers advance.
//   Overflow cannot occur: issue requires count+infl <= DEPTH-1.
//   Show-ahead head
//   - ir_valid = (count != 0).
//   - ir and ir_pc are the entry at rptr when valid, otherwise 0.
//   - Latency: Addr issued in cycle N -> ir_valid in cycle N+2 when the queue was empty.
//   Flush: on a posedge with pcWR=1 and stop=0:
//   - a pop in the same cycle is honoured (the decoder consumed the jump instruction);
//   - then count=0, rptr=wptr=0, infl=0; any same-cycle push is dropped.
//   - ir_valid=0 next cycle; refill resumes with the new Addr one cycle later.
//   stop=1: no issue, no pop, no flush; only the pending push completes.
//   Arithmetic
//   - Pointers are log2(DEPTH) bits and wrap naturally.
//   - count is log2(DEPTH)+1 bits and never wraps.
//   - Addr wrap 255->0 needs no special handling.
// TESTING
//   1 Reset mid-run: queue holds 3 entries, pulse rst=0 -> all outputs 0 the same cycle,
//     count=0 after release.
//   2 Stream: ir_ready=1, Addr 0,1,2,... -> first ir_valid at cycle 2 with ir_pc=0, then
//     one instruction per cycle, ir_pc increments by 1, fetch_hold stays 0.
//   3 Backpressure: ir_ready=0 with DEPTH=4 -> fetch_hold=1 once count+infl=4, mem_rd=0,
//     exactly 4 entries queued with tags 0..3; after ir_ready=1 the entries drain in order.
//   4 Flush: queue holds tags 5,6,7; pcWR=1 with ir_ready=1 -> tag 5 popped, 6/7 and the
//     in-flight read discarded; next ir_pc equals the new jump Addr (e.g. 0x20).
//   5 Stop: assert stop with infl=1 -> in-flight word pushed, no further mem_rd, no pop
//     even with ir_ready=1; deassert stop -> stream resumes with no duplicate or missing
//     ir_pc.
//   6 Wrap: Addr 0xFE,0xFF,0x00 -> ir_pc sequence FE,FF,00; FIFO pointers wrap past
//     entry 3 with no data corruption.

Source files
------------

// File: rtl/instr_fetch_queue.sv
// Fetch stage: issues ROM reads at the PC, tags each returned word with its address and
// buffers it in a show-ahead FIFO feeding the decoder; flushes on taken jumps.
module instr_fetch_queue #(
   parameter int unsigned IW    = 16,
   parameter int unsigned AW    = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          stop,
   input  logic [AW-1:0] Addr,
   input  logic          pcWR,
   output logic [AW-1:0] mem_addr,
   output logic          mem_rd,
   input  logic [IW-1:0] mem_data,
   output logic          fetch_hold,
   output logic [IW-1:0] ir,
   output logic [AW-1:0] ir_pc,
   output logic          ir_valid,
   input  logic          ir_ready
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned SW = CW + 1;

   logic [CW-1:0] count, count_nxt;
   logic [PW-1:0] rptr, rptr_nxt;
   logic [PW-1:0] wptr, wptr_nxt;
   logic          infl, infl_nxt;
   logic [AW-1:0] infl_addr, infl_addr_nxt;

   logic [IW-1:0] data_q [DEPTH];
   logic [AW-1:0] tag_q  [DEPTH];

   logic push, pop, flush;

   // Occupancy counts the outstanding read so a returning word always has a slot.
   assign fetch_hold = (SW'(count) + SW'(infl)) >= SW'(DEPTH);
   assign mem_rd     = rst & ~stop & ~fetch_hold & ~pcWR;
   assign mem_addr   = Addr;

   assign ir_valid = (count != '0);
   assign ir       = ir_valid ? data_q[rptr] : '0;
   assign ir_pc    = ir_valid ? tag_q[rptr]  : '0;

   assign push  = infl;
   assign pop   = ir_valid & ir_ready & ~stop;
   assign flush = pcWR & ~stop;

   always_comb begin
      count_nxt     = count;
      rptr_nxt      = rptr;
      wptr_nxt      = wptr;
      infl_nxt      = mem_rd;
      infl_addr_nxt = infl_addr;

      if (mem_rd) begin
         infl_addr_nxt = Addr;
      end

      // A flush honours the same-cycle pop implicitly: everything is discarded anyway.
      if (flush) begin
         count_nxt = '0;
         rptr_nxt  = '0;
         wptr_nxt  = '0;
         infl_nxt  = 1'b0;
      end else begin
         if (push) begin
            wptr_nxt = wptr + PW'(1);
         end
         if (pop) begin
            rptr_nxt = rptr + PW'(1);
         end
         case ({push, pop})
            2'b10:   count_nxt = count + CW'(1);
            2'b01:   count_nxt = count - CW'(1);
            default: count_nxt = count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count     <= '0;
         rptr      <= '0;
         wptr      <= '0;
         infl      <= 1'b0;
         infl_addr <= '0;
      end else begin
         count     <= count_nxt;
         rptr      <= rptr_nxt;
         wptr      <= wptr_nxt;
         infl      <= infl_nxt;
         infl_addr <= infl_addr_nxt;
      end
   end

   // Entry storage needs no reset; the head is masked by ir_valid.
   always_ff @(posedge clk) begin
      if (push && !flush) begin
         data_q[wptr] <= mem_data;
         tag_q[wptr]  <= infl_addr;
      end
   end

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: constant vector table, corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_instr_fetch_queue;

   localparam int unsigned IW    = 16;
   localparam int unsigned AW    = 8;
   localparam int unsigned DEPTH = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic          stop;
   logic [AW-1:0] Addr;
   logic          pcWR;
   logic [AW-1:0] mem_addr;
   logic          mem_rd;
   logic [IW-1:0] mem_data;
   logic          fetch_hold;
   logic [IW-1:0] ir;
   logic [AW-1:0] ir_pc;
   logic          ir_valid;
   logic          ir_ready;

   always #5 clk = ~clk;

   instr_fetch_queue #(.IW(IW), .AW(AW), .DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .stop       (stop),
      .Addr       (Addr),
      .pcWR       (pcWR),
      .mem_addr   (mem_addr),
      .mem_rd     (mem_rd),
      .mem_data   (mem_data),
      .fetch_hold (fetch_hold),
      .ir         (ir),
      .ir_pc      (ir_pc),
      .ir_valid   (ir_valid),
      .ir_ready   (ir_ready)
   );

   function automatic logic [IW-1:0] rom(input logic [AW-1:0] a);
      logic [7:0] t;
      t = a * 8'd3 + 8'd1;
      return {a ^ 8'h5A, t};
   endfunction

   // Synchronous ROM; garbage on idle cycles exposes mistimed pushes.
   always @(posedge clk) begin
      if (mem_rd) mem_data <= rom(mem_addr);
      else        mem_data <= IW'($urandom);
   end

   int passed = 0;
   int total  = 0;

   logic [AW-1:0] m_q [$];
   logic          m_infl;
   logic [AW-1:0] m_infl_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic model_reset();
      m_q.delete();
      m_infl      = 1'b0;
      m_infl_addr = '0;
   endtask

   // Drive one cycle, compare every output with the model, then advance the model.
   task automatic cycle(input logic s, input logic j, input logic rdy,
                        input logic [AW-1:0] a, output logic o_rd);
      logic          e_hold, e_rd, e_v;
      logic [AW-1:0] e_pc;
      logic [IW-1:0] e_ir;
      @(negedge clk);
      stop = s; pcWR = j; ir_ready = rdy; Addr = a;
      #1;
      e_hold = (m_q.size() + int'(m_infl)) >= int'(DEPTH);
      e_rd   = rst && !s && !e_hold && !j;
      e_v    = m_q.size() != 0;
      e_pc   = e_v ? m_q[0] : '0;
      e_ir   = e_v ? rom(m_q[0]) : '0;
      chk("mem_addr",   32'(mem_addr),   32'(a));
      chk("mem_rd",     32'(mem_rd),     32'(e_rd));
      chk("fetch_hold", 32'(fetch_hold), 32'(e_hold));
      chk("ir_valid",   32'(ir_valid),   32'(e_v));
      chk("ir_pc",      32'(ir_pc),      32'(e_pc));
      chk("ir",         32'(ir),         32'(e_ir));
      if (e_v && rdy && !s) void'(m_q.pop_front());
      if (j && !s) m_q.delete();
      else if (m_infl) m_q.push_back(m_infl_addr);
      m_infl = e_rd;
      if (e_rd) m_infl_addr = a;
      o_rd = e_rd;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0; stop = 1'b0; pcWR = 1'b0; ir_ready = 1'b1;
      #1;
      chk("rst_ir_valid",   32'(ir_valid),   32'd0);
      chk("rst_ir",         32'(ir),         32'd0);
      chk("rst_ir_pc",      32'(ir_pc),      32'd0);
      chk("rst_fetch_hold", 32'(fetch_hold), 32'd0);
      chk("rst_mem_rd",     32'(mem_rd),     32'd0);
      stop = 1'b1;
      model_reset();
      @(negedge clk);
      rst = 1'b1;
   endtask

   typedef struct {
      logic          s, j, rdy;
      logic [AW-1:0] a;
      logic          e_rd, e_hold, e_v;
      logic [AW-1:0] e_pc;
   } vec_t;

   vec_t tbl [19];

   initial begin
      logic          rd;
      logic [AW-1:0] pc, tgt;
      logic          s, j, rdy;

      // stream, backpressure to full, drain, flush with pop, stop, stop masking pcWR
      tbl[0]  = '{1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[1]  = '{1'b0, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[2]  = '{1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 8'h00};
      tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b1, 8'h01};
      tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b1, 8'h02};
      tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h05, 1'b1, 1'b0, 1'b1, 8'h02};
      tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h06, 1'b0, 1'b1, 1'b1, 8'h02};
      tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h06, 1'b0, 1'b1, 1'b1, 8'h02};
      tbl[8]  = '{1'b0, 1'b0, 1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 8'h02};
      tbl[9]  = '{1'b0, 1'b0, 1'b1, 8'h06, 1'b1, 1'b0, 1'b1, 8'h03};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 8'h20, 1'b0, 1'b0, 1'b1, 8'h04};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 8'h20, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[12] = '{1'b0, 1'b0, 1'b1, 8'h21, 1'b1, 1'b0, 1'b0, 8'h00};
      tbl[13] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h20};
      tbl[14] = '{1'b1, 1'b0, 1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 8'h20};
      tbl[15] = '{1'b0, 1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b1, 8'h20};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 8'h23, 1'b1, 1'b0, 1'b1, 8'h21};
      tbl[17] = '{1'b1, 1'b1, 1'b1, 8'h40, 1'b0, 1'b0, 1'b1, 8'h22};
      tbl[18] = '{1'b0, 1'b0, 1'b1, 8'h24, 1'b1, 1'b0, 1'b1, 8'h22};

      rst = 1'b0; stop = 1'b1; pcWR = 1'b0; ir_ready = 1'b0; Addr = '0;
      model_reset();
      do_reset();

      for (int i = 0; i < 19; i++) begin
         cycle(tbl[i].s, tbl[i].j, tbl[i].rdy, tbl[i].a, rd);
         chk($sformatf("tbl%0d_mem_rd", i),     32'(mem_rd),     32'(tbl[i].e_rd));
         chk($sformatf("tbl%0d_fetch_hold", i), 32'(fetch_hold), 32'(tbl[i].e_hold));
         chk($sformatf("tbl%0d_ir_valid", i),   32'(ir_valid),   32'(tbl[i].e_v));
         chk($sformatf("tbl%0d_ir_pc", i),      32'(ir_pc),      32'(tbl[i].e_pc));
      end

      // Reset while three entries are queued and a read is in flight.
      do_reset();
      for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 1'b0, 8'(i), rd);
      do_reset();
      cycle(1'b0, 1'b0, 1'b1, 8'h10, rd);
      chk("post_rst_ir_valid",   32'(ir_valid),   32'd0);
      chk("post_rst_fetch_hold", 32'(fetch_hold), 32'd0);

      // Address wrap FE, FF, 00 streams through in order.
      do_reset();
      pc = 8'hFE;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 1'b0, 1'b1, pc, rd);
         if (i == 2) chk("wrap_pc0", 32'(ir_pc), 32'h0FE);
         if (i == 3) chk("wrap_pc1", 32'(ir_pc), 32'h0FF);
         if (i == 4) chk("wrap_pc2", 32'(ir_pc), 32'h000);
         if (rd) pc = pc + 8'd1;
      end

      // Randomized traffic with a PC that follows fetch_hold, stop and jumps.
      do_reset();
      pc = 8'hF0;
      for (int i = 0; i < 800; i++) begin
         s   = ($urandom_range(0, 9) == 0);
         j   = ($urandom_range(0, 19) == 0);
         rdy = ($urandom_range(0, 9) < 6);
         tgt = 8'($urandom);
         cycle(s, j, rdy, pc, rd);
         if (j && !s) pc = tgt;
         else if (rd) pc = pc + 8'd1;
      end

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
